// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin scheduler sharing one timer among N_REQ requesters
// Grants one channel at a time, launches the timer and waits for expiry or watchdog abort.
module timer_scheduler #(
   parameter int N_REQ    = 4,
   parameter int CW       = 8,
   parameter int WD_SLACK = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*CW-1:0] period,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic [CW-1:0]      timer_circle,
   output logic               start_flag,
   input  logic               timer_over
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic [2:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [CW:0]   watchdog;

   logic          found;
   logic [PW-1:0] pick;

   // First requester at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         ptr          <= '0;
         gidx         <= '0;
         grant        <= '0;
         busy         <= 1'b0;
         done         <= '0;
         err          <= '0;
         start_flag   <= 1'b0;
         timer_circle <= '0;
         watchdog     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  timer_circle <= period[int'(pick)*CW +: CW];
                  grant        <= N_REQ'(1) << pick;
                  gidx         <= pick;
                  busy         <= 1'b1;
                  state        <= S_START;
               end
            end
            S_START: begin
               // A zero period completes immediately without touching the timer.
               if (timer_circle == '0) begin
                  done  <= grant;
                  grant <= '0;
                  state <= S_DONE;
               end else begin
                  start_flag <= 1'b1;
                  watchdog   <= {1'b0, timer_circle} + (CW+1)'(WD_SLACK);
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               start_flag <= 1'b0;
               // Expiry takes precedence over a watchdog that reaches zero the same cycle.
               if (timer_over) begin
                  done  <= grant;
                  grant <= '0;
                  state <= S_DONE;
               end else if (watchdog == '0) begin
                  err   <= grant;
                  grant <= '0;
                  state <= S_ERR;
               end else begin
                  watchdog <= watchdog - 1'b1;
               end
            end
            S_DONE, S_ERR: begin
               done  <= '0;
               err   <= '0;
               busy  <= 1'b0;
               ptr   <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed self-checking bench for timer_scheduler
// Includes a behavioural timer that pulses timer_over timer_circle cycles after start_flag.
module tb_timer_scheduler;

   logic        CLK;
   logic        RST;
   logic [3:0]  req;
   logic [31:0] period;
   logic [3:0]  grant;
   logic        busy;
   logic [3:0]  done;
   logic [3:0]  err;
   logic [7:0]  timer_circle;
   logic        start_flag;
   logic        timer_over;

   logic        model_over;
   logic        force_over;
   logic        timer_en;
   int          tcnt;

   int checks;
   int errors;

   int n_start;
   int n_done [4];
   int n_err  [4];
   int multi;
   int glog [$];
   logic [7:0] last_circle;
   logic [3:0] prev_grant;

   assign timer_over = model_over | force_over;

   timer_scheduler #(.N_REQ(4), .CW(8), .WD_SLACK(8)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .req          (req),
      .period       (period),
      .grant        (grant),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .timer_circle (timer_circle),
      .start_flag   (start_flag),
      .timer_over   (timer_over)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      model_over = 1'b0;
      tcnt       = 0;
   end

   always @(negedge CLK) begin
      model_over = 1'b0;
      if (RST) begin
         tcnt = 0;
      end else begin
         if (tcnt > 0) begin
            tcnt = tcnt - 1;
            if (tcnt == 0) model_over = 1'b1;
         end
         if (start_flag && timer_en) tcnt = int'(timer_circle);
      end
   end

   initial begin
      n_start     = 0;
      multi       = 0;
      last_circle = '0;
      prev_grant  = '0;
      for (int i = 0; i < 4; i++) begin
         n_done[i] = 0;
         n_err[i]  = 0;
      end
   end

   always @(negedge CLK) begin
      if (start_flag) begin
         n_start     = n_start + 1;
         last_circle = timer_circle;
      end
      for (int i = 0; i < 4; i++) begin
         if (done[i]) n_done[i] = n_done[i] + 1;
         if (err[i])  n_err[i]  = n_err[i] + 1;
      end
      if ($countones(grant) > 1) multi = multi + 1;
      if (grant != 4'b0 && prev_grant == 4'b0) begin
         for (int i = 0; i < 4; i++)
            if (grant[i]) glog.push_back(i);
      end
      prev_grant = grant;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      req = 4'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int bound, output int cyc);
      cyc = 0;
      while ((done | err) == 4'b0 && cyc < bound) begin
         @(negedge CLK);
         cyc = cyc + 1;
      end
      chk({tag, "_seen"}, 32'((done | err) != 4'b0), 32'd1);
   endtask

   task automatic wait_start(input string tag, input int bound);
      int cyc;
      cyc = 0;
      while (!start_flag && cyc < bound) begin
         @(negedge CLK);
         cyc = cyc + 1;
      end
      chk({tag, "_start"}, 32'(start_flag), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got 0 expected 1");
      $fatal(1, "time limit");
   end

   initial begin
      int c;
      int base_start;
      int base_err;
      int base_log;
      int base_done;
      int base_multi;
      int sum_done;
      int guard;

      checks     = 0;
      errors     = 0;
      RST        = 1'b1;
      req        = 4'b0;
      period     = '0;
      timer_en   = 1'b1;
      force_over = 1'b0;

      repeat (3) @(negedge CLK);
      chk("rst_grant",  32'(grant),        32'd0);
      chk("rst_busy",   32'(busy),         32'd0);
      chk("rst_done",   32'(done),         32'd0);
      chk("rst_err",    32'(err),          32'd0);
      chk("rst_start",  32'(start_flag),   32'd0);
      chk("rst_circle", 32'(timer_circle), 32'd0);
      RST = 1'b0;

      // single request, period 5
      @(negedge CLK);
      base_start = n_start;
      base_err   = n_err[1];
      period[15:8] = 8'd5;
      req = 4'b0010;
      @(negedge CLK);
      chk("t1_grant", 32'(grant), 32'h2);
      chk("t1_busy",  32'(busy),  32'd1);
      wait_out("t1", 40, c);
      chk("t1_done", 32'(done), 32'h2);
      chk("t1_lat",  32'(c),    32'd7);
      req = 4'b0;
      @(negedge CLK);
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_busy_low",   32'(busy), 32'd0);
      chk("t1_nstart", 32'(n_start - base_start), 32'd1);
      chk("t1_circle", 32'(last_circle),           32'd5);
      chk("t1_noerr",  32'(n_err[1] - base_err),   32'd0);

      // all four requesting, round-robin order
      do_reset();
      period = {8'd3, 8'd3, 8'd3, 8'd3};
      base_log   = glog.size();
      base_multi = multi;
      base_done  = n_done[0] + n_done[1] + n_done[2] + n_done[3];
      req = 4'b1111;
      guard = 0;
      while (glog.size() - base_log < 8 && guard < 300) begin
         @(negedge CLK);
         guard = guard + 1;
      end
      req = 4'b0;
      guard = 0;
      while (busy && guard < 50) begin
         @(negedge CLK);
         guard = guard + 1;
      end
      chk("t2_idle", 32'(busy), 32'd0);
      @(negedge CLK);
      chk("t2_ngrant", 32'(glog.size() - base_log), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (base_log + k < glog.size())
            chk("t2_order", 32'(glog[base_log + k]), 32'(k % 4));
      end
      sum_done = n_done[0] + n_done[1] + n_done[2] + n_done[3];
      chk("t2_done_per_grant", 32'(sum_done - base_done), 32'(glog.size() - base_log));
      chk("t2_onehot", 32'(multi - base_multi), 32'd0);

      // zero period: done right after grant, no start_flag
      do_reset();
      period = {8'd3, 8'd0, 8'd3, 8'd3};
      base_start = n_start;
      req = 4'b0100;
      @(negedge CLK);
      chk("t3_grant", 32'(grant), 32'h4);
      @(negedge CLK);
      chk("t3_done",  32'(done),       32'h4);
      chk("t3_nosf",  32'(start_flag), 32'd0);
      req = 4'b0;
      repeat (3) @(negedge CLK);
      chk("t3_nstart", 32'(n_start - base_start), 32'd0);

      // silent timer: watchdog abort, then pending channel 1
      do_reset();
      timer_en = 1'b0;
      period = {8'd3, 8'd3, 8'd2, 8'd10};
      req = 4'b0011;
      wait_start("t4", 10);
      chk("t4_grant", 32'(grant), 32'h1);
      wait_out("t4", 40, c);
      chk("t4_err",  32'(err),  32'h1);
      chk("t4_done", 32'(done), 32'd0);
      chk("t4_lat",  32'(c),    32'd19);
      req = 4'b0010;
      timer_en = 1'b1;
      @(negedge CLK);
      chk("t4_gap", 32'(grant), 32'd0);
      @(negedge CLK);
      chk("t4_grant1", 32'(grant), 32'h2);
      wait_out("t4b", 20, c);
      chk("t4_done1", 32'(done), 32'h2);
      req = 4'b0;

      // reset during WAIT of channel 3
      do_reset();
      period = {8'd20, 8'd3, 8'd3, 8'd4};
      base_done = n_done[3];
      req = 4'b1000;
      wait_start("t5", 10);
      chk("t5_grant", 32'(grant), 32'h8);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("t5_grant_rst", 32'(grant),      32'd0);
      chk("t5_busy_rst",  32'(busy),       32'd0);
      chk("t5_sf_rst",    32'(start_flag), 32'd0);
      RST = 1'b0;
      req = 4'b1001;
      @(negedge CLK);
      chk("t5_first", 32'(grant), 32'h1);
      wait_out("t5", 30, c);
      chk("t5_done0", 32'(done), 32'h1);
      req = 4'b0;
      repeat (25) @(negedge CLK);
      chk("t5_nodone3", 32'(n_done[3] - base_done), 32'd0);

      // timer_over coincident with watchdog zero, then stray timer_over
      do_reset();
      timer_en = 1'b0;
      period = {8'd3, 8'd3, 8'd3, 8'd2};
      req = 4'b0001;
      wait_start("t6", 10);
      repeat (10) @(negedge CLK);
      force_over = 1'b1;
      @(negedge CLK);
      force_over = 1'b0;
      chk("t6_done", 32'(done), 32'h1);
      chk("t6_err",  32'(err),  32'd0);
      req = 4'b0;
      repeat (3) @(negedge CLK);
      force_over = 1'b1;
      @(negedge CLK);
      force_over = 1'b0;
      chk("t6_stray_grant", 32'(grant),      32'd0);
      chk("t6_stray_busy",  32'(busy),       32'd0);
      chk("t6_stray_done",  32'(done),       32'd0);
      chk("t6_stray_err",   32'(err),        32'd0);
      @(negedge CLK);
      chk("t6_stray_out",   32'(done | err), 32'd0);
      chk("t6_stray_sf",    32'(start_flag), 32'd0);
      timer_en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
